// File: rtl/viterbi_pkg.sv
// viterbi_pkg: types and constants shared by the Viterbi traceback and output reorder stages.
package viterbi_pkg;

    typedef enum logic {IDLE, DRAIN} tb_state_e;

    localparam int TB_DEPTH_DEFAULT = 8;
    localparam int TRELLIS_STATES = 8;
    localparam int TRELLIS_W = $clog2(TRELLIS_STATES);

endpackage

// File: rtl/tb_bit_bank.sv
// tb_bit_bank: one DEPTH x 1 bank of the ping-pong buffer, single write port, async read port.
module tb_bit_bank
    import viterbi_pkg::*;
#(
    parameter int DEPTH = TB_DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic              i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic              o_rdata
);

    logic [DEPTH-1:0] r_mem;

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tb_lifo_buf.sv
// tb_lifo_buf: ping-pong LIFO that reverses each traceback block into oldest-first order.
// Optional sticky overflow flag output ovf_err when TB_LIFO_OVF_FLAG_EN is defined.
module tb_lifo_buf
    import viterbi_pkg::*;
#(
    parameter int DEPTH = TB_DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic d_in,
    input  logic wr_en,
    output logic d_out,
`ifdef TB_LIFO_OVF_FLAG_EN
    output logic ovf_err,
`endif
    output logic d_valid
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    tb_state_e         r_state, w_state_nxt;
    logic [1:0]        r_full, w_full_set, w_full_clr;
    logic              r_wbank, r_rbank, r_dout, r_dvalid;
    logic [ADDR_W-1:0] r_wptr, r_rptr;
    logic              w_wr_ok, w_wr_last, w_drain, w_rd_last;
    logic              w_rdata0, w_rdata1, w_rdata;

    // A bank accepts writes only while not full, so it is never drained and written at once
    assign w_wr_ok    = enable && wr_en && !r_full[r_wbank];
    assign w_wr_last  = r_wptr == LAST;
    assign w_drain    = r_state == DRAIN;
    assign w_rd_last  = w_drain && r_rptr == '0;
    assign w_rdata    = r_rbank ? w_rdata1 : w_rdata0;
    assign w_full_set = {2{w_wr_ok && w_wr_last}} & (r_wbank ? 2'b10 : 2'b01);
    assign w_full_clr = {2{w_rd_last}} & (r_rbank ? 2'b10 : 2'b01);

    tb_bit_bank #(.DEPTH(DEPTH)) u_bank0 (
        .clk     (clk),
        .i_we    (w_wr_ok && !r_wbank),
        .i_waddr (r_wptr),
        .i_wdata (d_in),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata0)
    );

    tb_bit_bank #(.DEPTH(DEPTH)) u_bank1 (
        .clk     (clk),
        .i_we    (w_wr_ok && r_wbank),
        .i_waddr (r_wptr),
        .i_wdata (d_in),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata1)
    );

    // Stay in DRAIN across banks when the other one is already waiting
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE) w_state_nxt = r_full[r_rbank] ? DRAIN : IDLE;
        else if (w_rd_last) w_state_nxt = r_full[~r_rbank] ? DRAIN : IDLE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else r_state <= enable ? w_state_nxt : IDLE;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_full   <= 2'b00;
            r_wbank  <= 1'b0;
            r_rbank  <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= LAST;
            r_dout   <= 1'b0;
            r_dvalid <= 1'b0;
        end else if (!enable) begin
            r_full   <= 2'b00;
            r_wbank  <= 1'b0;
            r_rbank  <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= LAST;
            r_dout   <= 1'b0;
            r_dvalid <= 1'b0;
        end else begin
            r_full   <= (r_full | w_full_set) & ~w_full_clr;
            r_dvalid <= w_drain;
            r_rptr   <= (w_drain && !w_rd_last) ? r_rptr - 1'b1 : LAST;
            if (w_drain) r_dout <= w_rdata;
            if (w_rd_last) r_rbank <= ~r_rbank;
            if (w_wr_ok) begin
                r_wptr  <= w_wr_last ? '0 : r_wptr + 1'b1;
                r_wbank <= r_wbank ^ w_wr_last;
            end
        end

    assign d_out   = r_dout;
    assign d_valid = r_dvalid;

`ifdef TB_LIFO_OVF_FLAG_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_ovf <= 1'b0;
        else r_ovf <= enable && (r_ovf || (wr_en && r_full[r_wbank]));

    assign ovf_err = r_ovf;
`else
    // Without the flag, a write into a full bank is silently dropped
`endif

endmodule

// File: tb/tb_tb_lifo_buf.sv
// tb_tb_lifo_buf: directed, table-driven checks of the traceback output reorder buffer.
module tb_tb_lifo_buf;

    logic clk = 1'b0, rst = 1'b0, enable = 1'b1, d_in = 1'b0, wr_en = 1'b0;
    logic d_out, d_valid;
`ifdef TB_LIFO_OVF_FLAG_EN
    logic ovf_err;
`endif

    tb_lifo_buf #(.DEPTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .d_in    (d_in),
        .wr_en   (wr_en),
        .d_out   (d_out),
`ifdef TB_LIFO_OVF_FLAG_EN
        .ovf_err (ovf_err),
`endif
        .d_valid (d_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {int cyc; logic b;} obs_t;
    obs_t q[$];

    always @(posedge clk) begin
        #1;
        if (d_valid === 1'b1) q.push_back('{cyc, d_out});
    end

    typedef struct {logic [7:0] din; int gap; logic [7:0] exp;} vec_t;
    vec_t vecs[4];

    int errs = 0, checks = 0;
    int l1, l2, l3, l4;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // din[i] is the i-th bit written; last returns the edge that captured bit 7
    task automatic write_blk(input logic [7:0] b, input int gap, output int last);
        for (int i = 0; i < 8; i++) begin
            d_in  = b[i];
            wr_en = 1'b1;
            step();
            last  = cyc;
            wr_en = 1'b0;
            d_in  = 1'b0;
            for (int j = 1; j < gap; j++) step();
        end
    endtask

    // exp[k] is the k-th bit expected out, on edge first+k
    task automatic chk_burst(input string nm, input int first, input logic [7:0] exp, input int off);
        for (int k = 0; k < 8; k++)
            if (off + k < q.size()) begin
                chk($sformatf("%s cyc%0d", nm, k), q[off+k].cyc, first + k);
                chk($sformatf("%s bit%0d", nm, k), q[off+k].b, exp[k]);
            end else
                chk($sformatf("%s missing%0d", nm, k), q.size(), off + k + 1);
    endtask

    initial begin
        vecs[0] = '{8'h53, 3, 8'hCA};
        vecs[1] = '{8'hFF, 1, 8'hFF};
        vecs[2] = '{8'h1E, 2, 8'h78};
        vecs[3] = '{8'h01, 1, 8'h80};

        #12;
        chk("reset d_valid", d_valid, 0);
        chk("reset d_out", d_out, 0);
        rst = 1'b1;
        step();

        // reset mid-run, then idle
        for (int i = 0; i < 4; i++) begin
            d_in = 1'b1; wr_en = 1'b1; step();
        end
        wr_en = 1'b0;
        #2 rst = 1'b0;
        step();
        rst = 1'b1;
        q.delete();
        repeat (20) step();
        chk("idle no output", q.size(), 0);
        chk("idle d_valid", d_valid, 0);
        chk("idle d_out", d_out, 0);

        // two blocks back-to-back, no bubble between bursts
        write_blk(8'h81, 1, l1);
        write_blk(8'h16, 1, l2);
        repeat (20) step();
        chk("b2b count", q.size(), 16);
        chk_burst("b2b blk1", l1 + 2, 8'h81, 0);
        chk_burst("b2b blk2", l1 + 10, 8'h68, 8);

        for (int v = 0; v < 4; v++) begin
            q.delete();
            write_blk(vecs[v].din, vecs[v].gap, l1);
            repeat (12) step();
            chk($sformatf("vec%0d count", v), q.size(), 8);
            chk_burst($sformatf("vec%0d", v), l1 + 2, vecs[v].exp, 0);
        end

        // overflow: first bit of the third block hits a still-full bank and is dropped
        q.delete();
        write_blk(8'hC1, 1, l1);
        write_blk(8'h2E, 1, l2);
        write_blk(8'hFF, 1, l3);
        repeat (12) step();
        chk("ovf count", q.size(), 16);
        chk_burst("ovf blk1", l1 + 2, 8'h83, 0);
        chk_burst("ovf blk2", l1 + 10, 8'h74, 8);
`ifdef TB_LIFO_OVF_FLAG_EN
        chk("ovf_err set", ovf_err, 1);
`endif
        repeat (10) step();
        chk("ovf blk3 held", q.size(), 16);
        q.delete();
        d_in = 1'b0; wr_en = 1'b1; step();
        l4 = cyc;
        wr_en = 1'b0;
        repeat (12) step();
        chk("ovf tail count", q.size(), 8);
        chk_burst("ovf tail", l4 + 2, 8'hFE, 0);
`ifdef TB_LIFO_OVF_FLAG_EN
        chk("ovf_err sticky", ovf_err, 1);
`endif

        // enable low after third output bit
        q.delete();
        write_blk(8'hB4, 1, l1);
        repeat (4) step();
        enable = 1'b0;
        step();
        chk("en0 d_valid", d_valid, 0);
        chk("en0 d_out", d_out, 0);
`ifdef TB_LIFO_OVF_FLAG_EN
        chk("en0 ovf_err", ovf_err, 0);
`endif
        enable = 1'b1;
        repeat (12) step();
        chk("en0 count", q.size(), 3);
        if (q.size() == 3) begin
            chk("en0 bit0", q[0].b, 1);
            chk("en0 bit1", q[1].b, 0);
            chk("en0 bit2", q[2].b, 1);
        end
        q.delete();
        write_blk(8'h6D, 1, l1);
        repeat (12) step();
        chk("en0 after count", q.size(), 8);
        chk_burst("en0 after", l1 + 2, 8'hB6, 0);

        // async reset at wptr=5, no clock edge needed
        q.delete();
        chk("hold d_out", d_out, 1);
        for (int i = 0; i < 5; i++) begin
            d_in = 1'b1; wr_en = 1'b1; step();
        end
        wr_en = 1'b0; d_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async d_out", d_out, 0);
        chk("async d_valid", d_valid, 0);
        step();
        step();
        rst = 1'b1;
        write_blk(8'h93, 1, l1);
        repeat (12) step();
        chk("post rst count", q.size(), 8);
        chk_burst("post rst", l1 + 2, 8'hC9, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
